// File: rtl/dsp_mac_pkg.sv
// Shared constants for the DSP48A1 dot-product sequencer: operand/P widths,
// slice latency and the OPMODE codes issued to the slice.
package dsp_mac_pkg;

    localparam int OPND_W  = 18;
    localparam int P_W     = 48;
    localparam int DSP_LAT = 3;

    localparam logic [7:0] OPM_FIRST = 8'h01;
    localparam logic [7:0] OPM_ACC   = 8'h09;
    localparam logic [7:0] OPM_HOLD  = 8'h08;

endpackage

// File: rtl/mac_result_fifo.sv
// Synchronous result FIFO with async active-low reset and an occupancy count.
// The head word reads as zero while the FIFO is empty.
module mac_result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 48
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is still taken when the head leaves on the same edge.
    assign do_pop  = pop & (count != '0);
    assign do_push = push & ((count != CW'(DEPTH)) | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign pop_data = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Issues operand pairs with OPMODE to a DSP48A1 slice and captures finished dot products.
// Optional MAC_BEAT_CNT_EN stores each vector's beat count and drives it on m_count.
module dsp_mac_sequencer
    import dsp_mac_pkg::*;
#(
    parameter int RES_DEPTH = 4,
    parameter int MAX_LEN   = 256,
    parameter int CNT_W     = $clog2(MAX_LEN + 1)
) (
    input  logic                     CLK,
    input  logic                     RSTN,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic signed [OPND_W-1:0] s_a,
    input  logic signed [OPND_W-1:0] s_b,
    input  logic                     s_last,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic signed [P_W-1:0]    m_data,
`ifdef MAC_BEAT_CNT_EN
    output logic [CNT_W-1:0]         m_count,
`endif
    output logic signed [OPND_W-1:0] dsp_a,
    output logic signed [OPND_W-1:0] dsp_b,
    output logic [7:0]               dsp_opmode,
    output logic                     dsp_ce,
    output logic                     dsp_rst,
    input  logic signed [P_W-1:0]    dsp_p
);

    localparam int STG = DSP_LAT + 1;
    localparam int FCW = $clog2(RES_DEPTH + 1);
    localparam int OCW = FCW + 3;
`ifdef MAC_BEAT_CNT_EN
    localparam int FIFO_W = P_W + CNT_W;
`else
    localparam int FIFO_W = P_W;
`endif

    logic [1:0]       rst_sync;
    logic             rst_hold;
    logic             accept;
    logic             eff_last;
    logic [CNT_W-1:0] beat_cnt;
    logic [7:0]       opm_q;
    logic [STG-1:0]   mark;
    logic [2:0]       inflight;
    logic [FCW-1:0]   fifo_count;
    logic [OCW-1:0]   occupancy;
    logic [FIFO_W-1:0] fifo_in;
    logic [FIFO_W-1:0] fifo_out;

    // Keeps the slice in reset for two edges after RSTN rises so its sync reset lands.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) rst_sync <= 2'b00;
        else       rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_hold = !rst_sync[1];
    assign dsp_rst  = rst_hold;
    assign dsp_ce   = 1'b1;

    assign accept   = s_valid & s_ready;
    assign eff_last = s_last | (beat_cnt == CNT_W'(MAX_LEN - 1));

    always_comb begin
        inflight = '0;
        for (int i = 0; i < STG; i++) inflight = inflight + 3'(mark[i]);
    end

    // Every in-flight marker already owns a FIFO slot, so dsp_p can never be dropped.
    assign occupancy = OCW'(fifo_count) + OCW'(inflight);
    assign s_ready   = !rst_hold && (occupancy < OCW'(RES_DEPTH));
    assign m_valid   = (fifo_count != '0);

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            dsp_a      <= '0;
            dsp_b      <= '0;
            opm_q      <= OPM_HOLD;
            dsp_opmode <= OPM_HOLD;
            beat_cnt   <= '0;
            mark       <= '0;
        end else begin
            dsp_a      <= accept ? s_a : '0;
            dsp_b      <= accept ? s_b : '0;
            opm_q      <= !accept ? OPM_HOLD : ((beat_cnt == '0) ? OPM_FIRST : OPM_ACC);
            dsp_opmode <= opm_q;
            if (accept) beat_cnt <= eff_last ? '0 : beat_cnt + 1'b1;
            mark <= {mark[STG-2:0], accept & eff_last};
        end
    end

`ifdef MAC_BEAT_CNT_EN
    logic [CNT_W-1:0] cnt_pipe [STG];

    // Beat count rides alongside the last marker so it meets its own dot product.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int i = 0; i < STG; i++) cnt_pipe[i] <= '0;
        end else begin
            cnt_pipe[0] <= beat_cnt + 1'b1;
            for (int i = 1; i < STG; i++) cnt_pipe[i] <= cnt_pipe[i-1];
        end
    end

    assign fifo_in = {cnt_pipe[STG-1], dsp_p};
    assign m_count = fifo_out[FIFO_W-1:P_W];
`else
    assign fifo_in = dsp_p;
`endif

    assign m_data = fifo_out[P_W-1:0];

    mac_result_fifo #(
        .DEPTH (RES_DEPTH),
        .WIDTH (FIFO_W)
    ) u_fifo (
        .clk       (CLK),
        .rst_n     (RSTN),
        .push      (mark[STG-1]),
        .push_data (fifo_in),
        .pop       (m_valid & m_ready),
        .pop_data  (fifo_out),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer with a behavioural DSP48A1 slice and a dot-product model.
// Builds with or without MAC_BEAT_CNT_EN.
module tb_dsp_mac_sequencer;

    localparam int MAX_LEN1 = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn;

    logic        s_valid, s_ready, s_last, m_valid, m_ready;
    logic [17:0] s_a, s_b;
    logic [47:0] m_data;
    logic [17:0] dsp_a, dsp_b;
    logic [7:0]  dsp_opmode;
    logic        dsp_ce, dsp_rst;
    logic [47:0] dsp_p;

    logic        s2_valid, s2_ready, s2_last, m2_valid, m2_ready;
    logic [17:0] s2_a, s2_b;
    logic [47:0] m2_data;
    logic [17:0] dsp2_a, dsp2_b;
    logic [7:0]  dsp2_opmode;
    logic        dsp2_ce, dsp2_rst;
    logic [47:0] dsp2_p;
`ifdef MAC_BEAT_CNT_EN
    logic [8:0]  m_count;
    logic [2:0]  m2_count;
`endif

    int tests_run    = 0;
    int tests_failed = 0;
    bit rand_ready   = 0;

    logic [47:0] exp_data_q [$];
    int          exp_cnt_q  [$];
    longint      cur_sum    = 0;
    int          cur_len    = 0;

    dsp_mac_sequencer dut (
        .CLK        (clk),
        .RSTN       (rstn),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_a        (s_a),
        .s_b        (s_b),
        .s_last     (s_last),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
`ifdef MAC_BEAT_CNT_EN
        .m_count    (m_count),
`endif
        .dsp_a      (dsp_a),
        .dsp_b      (dsp_b),
        .dsp_opmode (dsp_opmode),
        .dsp_ce     (dsp_ce),
        .dsp_rst    (dsp_rst),
        .dsp_p      (dsp_p)
    );

    dsp_mac_sequencer #(.MAX_LEN(4)) dut2 (
        .CLK        (clk),
        .RSTN       (rstn),
        .s_valid    (s2_valid),
        .s_ready    (s2_ready),
        .s_a        (s2_a),
        .s_b        (s2_b),
        .s_last     (s2_last),
        .m_valid    (m2_valid),
        .m_ready    (m2_ready),
        .m_data     (m2_data),
`ifdef MAC_BEAT_CNT_EN
        .m_count    (m2_count),
`endif
        .dsp_a      (dsp2_a),
        .dsp_b      (dsp2_b),
        .dsp_opmode (dsp2_opmode),
        .dsp_ce     (dsp2_ce),
        .dsp_rst    (dsp2_rst),
        .dsp_p      (dsp2_p)
    );

    // Slice models: A1/B1, M, OPMODE and P registers with synchronous reset.
    function automatic logic [47:0] slice_p(logic [7:0] opm, logic [35:0] m, logic [47:0] p);
        logic [47:0] x;
        logic [47:0] z;
        x = (opm[1:0] == 2'b01) ? {{12{m[35]}}, m} : 48'd0;
        z = (opm[3:2] == 2'b10) ? p : 48'd0;
        return x + z;
    endfunction

    logic signed [17:0] sa1, sb1, s2a1, s2b1;
    logic signed [35:0] sm, s2m;
    logic [7:0]         sopm, s2opm;

    always @(posedge clk) begin
        if (dsp_rst) begin
            sa1 <= '0; sb1 <= '0; sm <= '0; sopm <= '0; dsp_p <= '0;
        end else if (dsp_ce) begin
            sa1   <= dsp_a;
            sb1   <= dsp_b;
            sm    <= 36'(sa1) * 36'(sb1);
            sopm  <= dsp_opmode;
            dsp_p <= slice_p(sopm, sm, dsp_p);
        end
    end

    always @(posedge clk) begin
        if (dsp2_rst) begin
            s2a1 <= '0; s2b1 <= '0; s2m <= '0; s2opm <= '0; dsp2_p <= '0;
        end else if (dsp2_ce) begin
            s2a1   <= dsp2_a;
            s2b1   <= dsp2_b;
            s2m    <= 36'(s2a1) * 36'(s2b1);
            s2opm  <= dsp2_opmode;
            dsp2_p <= slice_p(s2opm, s2m, dsp2_p);
        end
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Reference: a dot product closes on s_last or when the vector reaches MAX_LEN beats.
    task automatic model_accept(input logic [17:0] a, input logic [17:0] b, input logic last);
        cur_sum = cur_sum + longint'($signed(a)) * longint'($signed(b));
        cur_len++;
        if (last || cur_len == MAX_LEN1) begin
            exp_data_q.push_back(cur_sum[47:0]);
            exp_cnt_q.push_back(cur_len);
            cur_sum = 0;
            cur_len = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) m_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic idle();
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_a     = '0;
        s_b     = '0;
    endtask

    task automatic applyStimulus(input logic [17:0] a, input logic [17:0] b, input logic last);
        bit done = 0;
        s_valid = 1'b1;
        s_a     = a;
        s_b     = b;
        s_last  = last;
        for (int i = 0; i < 200 && !done; i++) begin
            if (s_ready) begin
                model_accept(a, b, last);
                done = 1;
            end
            tick();
        end
        check("send_timeout", 64'(done), 64'd1);
    endtask

    task automatic send2(input logic [17:0] a, input logic [17:0] b, input logic last);
        bit done = 0;
        s2_valid = 1'b1;
        s2_a     = a;
        s2_b     = b;
        s2_last  = last;
        for (int i = 0; i < 200 && !done; i++) begin
            if (s2_ready) done = 1;
            tick();
        end
        s2_valid = 1'b0;
        s2_last  = 1'b0;
        check("send2_timeout", 64'(done), 64'd1);
    endtask

    task automatic checkOutput(input string tag, input logic [47:0] data, input int cnt);
        bit found = 0;
        m_ready = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_valid) found = 1;
            else tick();
        end
        check({tag, "_valid"}, 64'(found), 64'd1);
        check({tag, "_data"}, 64'(m_data), 64'(data));
`ifdef MAC_BEAT_CNT_EN
        check({tag, "_count"}, 64'(m_count), 64'(cnt));
`else
        if (cnt < 0) $display("[TB] negative count %0d", cnt);
`endif
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
    endtask

    task automatic check_output2(input string tag, input logic [47:0] data, input int cnt);
        bit found = 0;
        m2_ready = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (m2_valid) found = 1;
            else tick();
        end
        check({tag, "_valid"}, 64'(found), 64'd1);
        check({tag, "_data"}, 64'(m2_data), 64'(data));
`ifdef MAC_BEAT_CNT_EN
        check({tag, "_count"}, 64'(m2_count), 64'(cnt));
`else
        if (cnt < 0) $display("[TB] negative count %0d", cnt);
`endif
        m2_ready = 1'b1;
        tick();
        m2_ready = 1'b0;
    endtask

    task automatic drain(input string tag);
        bit done = 0;
        m_ready = 1'b1;
        for (int i = 0; i < 400 && !done; i++) begin
            if (exp_data_q.size() == 0 && !m_valid) done = 1;
            else tick();
        end
        check({tag, "_drained"}, 64'(done), 64'd1);
        m_ready = 1'b0;
    endtask

    // Every popped result is compared against the model's next expected dot product.
    always @(negedge clk) begin
        if (rstn && m_valid && m_ready) begin
            if (exp_data_q.size() == 0) begin
                check("unexpected_result", 64'(m_valid), 64'd0);
            end else begin
                check("model_data", 64'(m_data), 64'(exp_data_q.pop_front()));
`ifdef MAC_BEAT_CNT_EN
                check("model_count", 64'(m_count), 64'(exp_cnt_q.pop_front()));
`else
                void'(exp_cnt_q.pop_front());
`endif
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [17:0] a_arr [6];
        logic [17:0] b_arr [6];
        int          accepted;
        int          len;

        rstn = 1'b0;
        m_ready = 1'b0;
        idle();
        s2_valid = 1'b0; s2_last = 1'b0; s2_a = '0; s2_b = '0; m2_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_s_ready", 64'(s_ready), 64'd0);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_m_data", 64'(m_data), 64'd0);
        check("rst_dsp_a", 64'(dsp_a), 64'd0);
        check("rst_dsp_b", 64'(dsp_b), 64'd0);
        check("rst_opmode", 64'(dsp_opmode), 64'h08);
        check("rst_dsp_rst", 64'(dsp_rst), 64'd1);
        check("rst_dsp_ce", 64'(dsp_ce), 64'd1);

        rstn = 1'b1;
        check("rel0_s_ready", 64'(s_ready), 64'd0);
        tick();
        check("rel1_s_ready", 64'(s_ready), 64'd0);
        check("rel1_dsp_rst", 64'(dsp_rst), 64'd1);
        tick();
        check("rel2_s_ready", 64'(s_ready), 64'd1);
        check("rel2_dsp_rst", 64'(dsp_rst), 64'd0);

        // Single beat: operand register, OPMODE one stage later, result at e4.
        applyStimulus(18'd3, 18'd4, 1'b1);
        idle();
        check("single_dsp_a", 64'(dsp_a), 64'd3);
        check("single_dsp_b", 64'(dsp_b), 64'd4);
        tick();
        check("single_opm_first", 64'(dsp_opmode), 64'h01);
        check("single_dsp_a_idle", 64'(dsp_a), 64'd0);
        tick();
        check("single_opm_hold", 64'(dsp_opmode), 64'h08);
        tick();
        check("single_e3_no_valid", 64'(m_valid), 64'd0);
        tick();
        check("single_e4_valid", 64'(m_valid), 64'd1);
        checkOutput("single", 48'd12, 1);
        check("single_popped", 64'(m_valid), 64'd0);

        applyStimulus(18'd1, 18'd2, 1'b0);
        applyStimulus(18'd3, 18'd4, 1'b0);
        check("vec_opm_first", 64'(dsp_opmode), 64'h01);
        applyStimulus(18'd5, 18'd6, 1'b1);
        check("vec_opm_acc", 64'(dsp_opmode), 64'h09);
        idle();
        checkOutput("vec3", 48'd44, 3);

        applyStimulus(18'h3FFFE, 18'd7, 1'b0);
        applyStimulus(18'd3, 18'd3, 1'b1);
        idle();
        checkOutput("signed", 48'hFFFF_FFFF_FFFB, 2);

        m_ready = 1'b1;
        applyStimulus(18'd2, 18'd2, 1'b1);
        applyStimulus(18'd5, 18'd5, 1'b1);
        idle();
        tick();
        tick();
        check("b2b_e3_no_valid", 64'(m_valid), 64'd0);
        tick();
        check("b2b_first_valid", 64'(m_valid), 64'd1);
        check("b2b_first_data", 64'(m_data), 64'd4);
        tick();
        check("b2b_second_valid", 64'(m_valid), 64'd1);
        check("b2b_second_data", 64'(m_data), 64'd25);
        tick();
        check("b2b_empty", 64'(m_valid), 64'd0);
        m_ready = 1'b0;

        // Backpressure: six single-beat vectors against a four-entry result FIFO.
        for (int i = 0; i < 6; i++) begin
            a_arr[i] = 18'($urandom);
            b_arr[i] = 18'($urandom);
        end
        accepted = 0;
        for (int i = 0; i < 12; i++) begin
            s_valid = 1'b1;
            s_a     = a_arr[accepted];
            s_b     = b_arr[accepted];
            s_last  = 1'b1;
            if (s_ready) begin
                model_accept(a_arr[accepted], b_arr[accepted], 1'b1);
                accepted++;
            end
            tick();
        end
        check("bp_accepted", 64'(accepted), 64'd4);
        check("bp_s_ready_low", 64'(s_ready), 64'd0);
        check("bp_m_valid", 64'(m_valid), 64'd1);
        m_ready = 1'b1;
        while (accepted < 6) begin
            applyStimulus(a_arr[accepted], b_arr[accepted], 1'b1);
            accepted++;
        end
        idle();
        drain("bp");

        // Reset in the middle of a vector with a stored result pending.
        applyStimulus(18'd9, 18'd9, 1'b1);
        idle();
        repeat (6) tick();
        check("pre_rst_valid", 64'(m_valid), 64'd1);
        applyStimulus(18'd7, 18'd7, 1'b0);
        applyStimulus(18'd1, 18'd1, 1'b0);
        idle();
        rstn = 1'b0;
        #1;
        exp_data_q.delete();
        exp_cnt_q.delete();
        cur_sum = 0;
        cur_len = 0;
        check("mid_rst_s_ready", 64'(s_ready), 64'd0);
        check("mid_rst_m_valid", 64'(m_valid), 64'd0);
        check("mid_rst_m_data", 64'(m_data), 64'd0);
        check("mid_rst_dsp_a", 64'(dsp_a), 64'd0);
        check("mid_rst_opmode", 64'(dsp_opmode), 64'h08);
        check("mid_rst_dsp_rst", 64'(dsp_rst), 64'd1);
        tick();
        rstn = 1'b1;
        check("mid_rel0_s_ready", 64'(s_ready), 64'd0);
        tick();
        check("mid_rel1_s_ready", 64'(s_ready), 64'd0);
        tick();
        check("mid_rel2_s_ready", 64'(s_ready), 64'd1);
        applyStimulus(18'd1, 18'd1, 1'b1);
        idle();
        checkOutput("post_rst", 48'd1, 1);

        // Randomized vectors with input gaps and random output backpressure.
        rand_ready = 1;
        for (int v = 0; v < 40; v++) begin
            len = $urandom_range(1, 6);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 3) == 0) begin
                    idle();
                    tick();
                end
                applyStimulus(18'($urandom), 18'($urandom), 1'(k == len - 1));
            end
        end
        idle();
        rand_ready = 0;
        drain("rand");

        // Forced last at MAX_LEN=4: five beats give 4 and then 1.
        for (int k = 0; k < 4; k++) send2(18'd1, 18'd1, 1'b0);
        send2(18'd1, 18'd1, 1'b1);
        check_output2("maxlen_first", 48'd4, 4);
        check_output2("maxlen_second", 48'd1, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
